// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_responder_pkg;

  localparam int          WORD_W            = 32;
  localparam int          BE_W              = WORD_W / 8;
  localparam int          CNT_W             = 4;
  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Word index relative to the base; addresses below the base wrap to huge indices.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, asynchronous read, no reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time,
// WAIT_CYCLES extra wait states, then a held response until accepted.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       idx;
  logic              acc_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign idx     = word_index(req_q.addr, ADDR_BASE);
  assign acc_err = (req_q.addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (idx[AW-1:0]),
    .be_i    (req_q.be),
    .wdata_i (req_q.wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    req_ready   = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.be    = req_be;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Store commits and load samples on the same edge the response is registered.
          mem_we      = req_q.we && !acc_err;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (req_q.we || acc_err) ? '0 : mem_rdata;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a 2-wait-state responder for directed vectors and a
// zero-wait-state build for latency/throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [3:0]  req_be0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

  dmem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_be(req_be0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  exp_t q[$];
  exp_t q0[$];
  exp_t em, em0;

  int   nvec = 0, nerr = 0;
  int   cyc = 0, acc_cyc = 0, acc0_cyc = 0, acc0_cnt = 0, last_hs0 = -1;
  logic prev_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cycle count and accept timestamps; acc_cyc equals the edge number of the accept.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc <= cyc + 1;
    if (req_valid0 && req_ready0) begin
      acc0_cyc <= cyc + 1;
      acc0_cnt <= acc0_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) check("latency_w2", 32'(cyc - acc_cyc), 32'd3);
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, expected none", rsp_rdata, rsp_err);
      end else begin
        em = q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(em.err));
        check("rsp_rdata", rsp_rdata, em.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid0) begin
      check("latency_w0", 32'(cyc - acc0_cyc), 32'd1);
      if (last_hs0 >= 0) check("spacing_w0", 32'(cyc - last_hs0), 32'd3);
      last_hs0 = cyc;
      if (q0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_rsp0: got rdata %h err %b, expected none", rsp_rdata0, rsp_err0);
      end else begin
        em0 = q0.pop_front();
        check("rsp_err0", 32'(rsp_err0), 32'(em0.err));
        check("rsp_rdata0", rsp_rdata0, em0.rdata);
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic push,
                       input logic eerr, input logic [31:0] erd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    if (push) q.push_back('{eerr, erd});
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Scramble inputs after acceptance; the captured request must be used.
    req_valid = 1'b0; req_we = ~we; req_be = ~be; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 200) begin @(negedge clk); n++; end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("rsp_valid_arrives", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req_valid = 0; req_we = 0; req_be = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
    req_valid0 = 0; req_we0 = 0; req_be0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 1;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    issue(1, 4'hF, 32'h1001_0004, 32'hDEAD_BEEF, 1, 0, 32'h0);
    issue(0, 4'hF, 32'h1001_0004, 32'h0,         1, 0, 32'hDEAD_BEEF);
    issue(1, 4'b0101, 32'h1001_0004, 32'h1122_3344, 1, 0, 32'h0);
    issue(0, 4'h0, 32'h1001_0004, 32'h0,         1, 0, 32'hDE22_BE44);
    issue(1, 4'hF, 32'h1001_0000, 32'hCAFE_F00D, 1, 0, 32'h0);
    issue(0, 4'hF, 32'h1001_0000, 32'h0,         1, 0, 32'hCAFE_F00D);
    issue(0, 4'hF, 32'h1001_0002, 32'h0,         1, 1, 32'h0);
    issue(1, 4'hF, 32'h1001_1000, 32'h1234_5678, 1, 1, 32'h0);
    issue(0, 4'hF, 32'h1001_0000, 32'h0,         1, 0, 32'hCAFE_F00D);
    issue(0, 4'hF, 32'h1000_FFFC, 32'h0,         1, 1, 32'h0);
    issue(1, 4'h0, 32'h1001_0004, 32'hFFFF_FFFF, 1, 0, 32'h0);
    issue(0, 4'hF, 32'h1001_0004, 32'h0,         1, 0, 32'hDE22_BE44);
    issue(1, 4'hF, 32'h1001_0FFC, 32'hA5A5_A5A5, 1, 0, 32'h0);
    issue(0, 4'hF, 32'h1001_0FFC, 32'h0,         1, 0, 32'hA5A5_A5A5);
    wait_idle();

    // Backpressure: response held for 5 cycles.
    rsp_ready = 1'b0;
    issue(0, 4'hF, 32'h1001_0004, 32'h0, 1, 0, 32'hDE22_BE44);
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDE22_BE44);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_idle();

    // Reset one cycle after a store is accepted: the store must be dropped.
    issue(1, 4'hF, 32'h1001_0004, 32'h0BAD_F00D, 0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midwait_rsp_rdata", rsp_rdata, 32'd0);
    check("midwait_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(0, 4'hF, 32'h1001_0004, 32'h0, 1, 0, 32'hDE22_BE44);
    wait_idle();

    // Reset while the store response is pending: the store already committed.
    rsp_ready = 1'b0;
    issue(1, 4'hF, 32'h1001_0004, 32'h7777_7777, 0, 0, 32'h0);
    wait_rsp_valid();
    reset = 1'b0;
    #1;
    check("resp_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    issue(0, 4'hF, 32'h1001_0004, 32'h0, 1, 0, 32'h7777_7777);
    wait_idle();

    // Zero-wait build: one store then back-to-back loads with the request held valid.
    @(negedge clk);
    q0.push_back('{1'b0, 32'h0});
    for (int i = 0; i < 4; i++) q0.push_back('{1'b0, 32'h55AA_33CC});
    req_we0 = 1'b1; req_be0 = 4'hF; req_addr0 = 32'h1001_0014; req_wdata0 = 32'h55AA_33CC;
    req_valid0 = 1'b1;
    n = 0;
    while (acc0_cnt < 1 && n < 20) begin @(negedge clk); n++; end
    req_we0 = 1'b0;
    while (acc0_cnt < 5 && n < 100) begin @(negedge clk); n++; end
    req_valid0 = 1'b0;
    check("w0_accepts", 32'(acc0_cnt), 32'd5);
    n = 0;
    while (q0.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("w0_drain", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
